ffa_arbiter: RTL
================

FFA_ARBITER -- requirements
Module: ffa_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 8, entry width
- ADDR_W, 3, address width
- DATA_N, 8, entry count, at most 2^ADDR_W
- REQ_N, 2, requester count, 2..4
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  REQ_N  request pending, one bit per requester
- req_wr  in  REQ_N  1 = write, 0 = read
- req_addr  in  REQ_N*ADDR_W  requester i at [i*ADDR_W +: ADDR_W]
- req_din  in  REQ_N*DATA_W  requester i at [i*DATA_W +: DATA_W]
- req_ready  out  REQ_N  grant; transfer occurs when valid & ready
- rsp_valid  out  REQ_N  one-cycle response pulse to requester i
- rsp_data  out  DATA_W  read data
- rsp_error  out  1  response error
- init_done  out  1  array initialised, arbitration enabled
- ffa_wr, ffa_rd  out  1 each  array write / read strobes
- ffa_addr  out  ADDR_W  array address
- ffa_din  out  DATA_W  array write data
- ffa_dout  in  DATA_W  array read data, combinational
- ffa_error  in  1  array error flag, combinational

Function
REQ-003 The FSM SHALL have two states, INIT and RUN; reset SHALL enter INIT with init counter = 0.
REQ-004 In INIT, the block SHALL drive ffa_wr=1, ffa_addr=counter and ffa_din=0, and increment the counter every cycle.
REQ-005 After the write to address DATA_N-1, the FSM SHALL move to RUN; INIT SHALL last exactly DATA_N cycles, and init_done SHALL be 1 only in RUN.
REQ-006 req_ready SHALL be all-zero in INIT and while reset is high.
REQ-007 In RUN, the grant SHALL go to the first requester with req_valid=1, searching upward from rr_ptr modulo REQ_N; req_ready SHALL be one-hot or zero.
REQ-008 After a grant to requester i, rr_ptr SHALL become (i+1) mod REQ_N; with no grant, rr_ptr SHALL hold.
REQ-009 In the grant cycle, the granted request SHALL drive ffa_wr=req_wr, ffa_rd=~req_wr, ffa_addr and ffa_din.
REQ-010 ffa_wr and ffa_rd SHALL never be 1 together; with no grant in RUN, all ffa_* outputs SHALL be 0.
REQ-011 If a granted address is >= DATA_N, the request SHALL still be granted, but ffa_wr and ffa_rd SHALL stay 0 and the response SHALL carry rsp_error=1 and rsp_data=0.
REQ-012 Response latency SHALL be 1 cycle: for a grant in cycle N, rsp_valid SHALL pulse one-hot for the granted requester in cycle N+1.
REQ-013 For reads, rsp_data and rsp_error SHALL be ffa_dout and ffa_error registered in cycle N.
REQ-014 For in-range writes, rsp_data SHALL be 0 and rsp_error SHALL be 0.
REQ-015 rsp_valid SHALL have no backpressure; rsp_data and rsp_error SHALL be 0 when no response is valid.
REQ-016 Inputs of non-granted requesters SHALL be ignored; a requester SHALL hold req_wr, req_addr and req_din stable while req_valid=1 and req_ready=0.
REQ-017 A write granted in cycle N followed by a read of the same address granted in cycle N+1 SHALL return the written data.
REQ-018 A single valid requester SHALL be granted every cycle, at full throughput.

Reset
REQ-019 While reset=1, the block SHALL drive req_ready=0, rsp_valid=0, rsp_data=0, rsp_error=0, init_done=0 and all ffa_* outputs = 0.
REQ-020 Reset SHALL set rr_ptr=0 and the init counter to 0.
REQ-021 Reset asserted in any state (mid-INIT, or the cycle after a grant) SHALL discard any pending response and restart INIT at address 0.

Verification
REQ-022 The bench SHALL cover the following scenarios:
- Release reset -> ffa_wr=1 for 8 cycles, addr 0..7, din 0x00; init_done rises in cycle 8; req_ready=0 throughout INIT.
- Requester 0 writes addr 3 with 0xA5, then requester 1 reads addr 3 -> rsp_valid=2'b10, rsp_data=0xA5, rsp_error=0.
- Both requesters hold reads valid for 6 cycles -> grants go 0,1,0,1,0,1; rsp_valid follows 1 cycle later.
- Read of unwritten addr 5 after INIT -> rsp_data=0x00, rsp_error=0.
- DATA_N=6: read of addr 7 -> ffa_rd stays 0; rsp_error=1, rsp_data=0.
- Reset asserted the cycle after a grant -> no rsp_valid; INIT restarts at addr 0.
REQ-023 The bench SHALL assert on every cycle: ffa_wr & ffa_rd never both 1, $onehot0(req_ready), and $onehot0(rsp_valid).

Source files
------------

// File: rtl/ffa_arbiter.sv
// rtl/ffa_arbiter.sv - round-robin arbiter in front of a flop array, with a zeroing init sweep
module ffa_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_N = 8,
  parameter int REQ_N  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REQ_N-1:0]         req_valid,
  input  logic [REQ_N-1:0]         req_wr,
  input  logic [REQ_N*ADDR_W-1:0]  req_addr,
  input  logic [REQ_N*DATA_W-1:0]  req_din,
  output logic [REQ_N-1:0]         req_ready,
  output logic [REQ_N-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_error,
  output logic                     init_done,
  output logic                     ffa_wr,
  output logic                     ffa_rd,
  output logic [ADDR_W-1:0]        ffa_addr,
  output logic [DATA_W-1:0]        ffa_din,
  input  logic [DATA_W-1:0]        ffa_dout,
  input  logic                     ffa_error
);

  localparam int                PTR_W     = (REQ_N > 2) ? 2 : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_N - 1);
  localparam logic [ADDR_W:0]   LIMIT     = (ADDR_W+1)'(DATA_N);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  init_cnt, init_cnt_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;
  logic [REQ_N-1:0]   grant_vec;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_din;
  logic               sel_wr;
  logic               sel_oor;
  logic [REQ_N-1:0]   rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_error_q;

  // First valid requester at or above rr_ptr, wrapping modulo REQ_N.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < REQ_N; k++) begin
      idx = (int'(rr_ptr) + k) % REQ_N;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
    if (reset || state != S_RUN) begin
      grant_any = 1'b0;
    end
  end

  assign sel_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_din   = req_din[int'(grant_idx)*DATA_W +: DATA_W];
  assign sel_wr    = req_wr[grant_idx];
  assign sel_oor   = {1'b0, sel_addr} >= LIMIT;
  assign grant_vec = grant_any ? (REQ_N'(1) << grant_idx) : '0;
  assign req_ready = grant_vec;

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    rr_ptr_nxt   = rr_ptr;
    ffa_wr       = 1'b0;
    ffa_rd       = 1'b0;
    ffa_addr     = '0;
    ffa_din      = '0;
    case (state)
      S_INIT: begin
        ffa_wr       = 1'b1;
        ffa_addr     = init_cnt;
        init_cnt_nxt = init_cnt + ADDR_W'(1);
        if (init_cnt == LAST_ADDR) begin
          state_nxt    = S_RUN;
          init_cnt_nxt = '0;
        end
      end
      S_RUN: begin
        if (grant_any) begin
          rr_ptr_nxt = (grant_idx == PTR_W'(REQ_N - 1)) ? '0 : grant_idx + PTR_W'(1);
          // Out-of-range addresses are granted but never reach the array.
          if (!sel_oor) begin
            ffa_wr   = sel_wr;
            ffa_rd   = ~sel_wr;
            ffa_addr = sel_addr;
            ffa_din  = sel_din;
          end
        end
      end
    endcase
    if (reset) begin
      ffa_wr   = 1'b0;
      ffa_rd   = 1'b0;
      ffa_addr = '0;
      ffa_din  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_INIT;
      init_cnt    <= '0;
      rr_ptr      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      init_cnt    <= init_cnt_nxt;
      rr_ptr      <= rr_ptr_nxt;
      rsp_valid_q <= grant_vec;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      if (grant_any) begin
        if (sel_oor) begin
          rsp_error_q <= 1'b1;
        end else if (!sel_wr) begin
          rsp_data_q  <= ffa_dout;
          rsp_error_q <= ffa_error;
        end
      end
    end
  end

  // Masking with reset drops a response still in flight when reset arrives.
  assign rsp_valid = reset ? '0 : rsp_valid_q;
  assign rsp_data  = reset ? '0 : rsp_data_q;
  assign rsp_error = reset ? 1'b0 : rsp_error_q;
  assign init_done = !reset && (state == S_RUN);

endmodule
